rvic_claim_ctrl: RTL and testbench

Interrupt claim/complete sequencer between the RVIC priority core and the CPU trap interface. It takes the core's current highest-priority pending candidate, gates it against a software threshold and the priority of the interrupt in service, and raises a registered request to the CPU. It tracks claimed interrupts on a nesting stack so higher-priority interrupts can preempt lower ones, and returns pending-clear pulses to the RVIC register block.

---
 rtl/rvic_claim_ctrl_if.sv | 26 ++
 rtl/rvic_claim_ctrl.sv | 78 +++++++
 tb/tb_rvic_claim_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/rvic_claim_ctrl_if.sv
// rvic_claim_ctrl_if: candidate/claim/complete bus between RVIC core, CPU trap logic and the claim controller
interface rvic_claim_ctrl_if #(parameter int PRIO_W = 8);
  logic              cand_valid_i;
  logic [4:0]        cand_id_i;
  logic [PRIO_W-1:0] cand_prio_i;
  logic [PRIO_W-1:0] threshold_i;
  logic              claim_i;
  logic              complete_i;
  logic [4:0]        complete_id_i;
  logic              err_clr_i;
  logic              irq_o;
  logic [7:0]        irq_id_o;
  logic              clr_pend_o;
  logic [4:0]        clr_id_o;
  logic [PRIO_W-1:0] cur_prio_o;
  logic [3:0]        depth_o;
  logic              err_o;
  modport slave (
    input  cand_valid_i, cand_id_i, cand_prio_i, threshold_i, claim_i, complete_i, complete_id_i, err_clr_i,
    output irq_o, irq_id_o, clr_pend_o, clr_id_o, cur_prio_o, depth_o, err_o
  );
  modport master (
    output cand_valid_i, cand_id_i, cand_prio_i, threshold_i, claim_i, complete_i, complete_id_i, err_clr_i,
    input  irq_o, irq_id_o, clr_pend_o, clr_id_o, cur_prio_o, depth_o, err_o
  );
endinterface

// File: rtl/rvic_claim_ctrl.sv
// rvic_claim_ctrl: gates RVIC candidates against threshold/in-service priority, offers them to the CPU and tracks nesting
module rvic_claim_ctrl #(
  parameter int NEST_DEPTH = 4,
  parameter int PRIO_W     = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  rvic_claim_ctrl_if.slave bus
);
  localparam int AW = NEST_DEPTH > 1 ? $clog2(NEST_DEPTH) : 1;
  typedef enum logic {IDLE, REQ} state_e;
  state_e            state_q, state_d;
  logic [4:0]        lat_id_q, lat_id_d;
  logic [PRIO_W-1:0] lat_prio_q, lat_prio_d;
  logic [4:0]        stk_id_q [NEST_DEPTH];
  logic [4:0]        stk_id_d [NEST_DEPTH];
  logic [PRIO_W-1:0] stk_prio_q [NEST_DEPTH];
  logic [PRIO_W-1:0] stk_prio_d [NEST_DEPTH];
  logic [3:0]        depth_q, depth_d, pop_depth;
  logic [PRIO_W-1:0] cur_prio_q, cur_prio_d, eff_thr;
  logic [4:0]        clr_id_q, clr_id_d;
  logic              clr_pend_q, clr_pend_d, err_q, err_d;
  logic              qual, push, pop;
  always_comb begin
    eff_thr    = bus.threshold_i > cur_prio_q ? bus.threshold_i : cur_prio_q;
    qual       = bus.cand_valid_i && bus.cand_prio_i > eff_thr && depth_q < 4'(NEST_DEPTH);
    push       = bus.claim_i && state_q == REQ;
    pop        = bus.complete_i && depth_q != 4'd0 && bus.complete_id_i == stk_id_q[AW'(depth_q - 4'd1)];
    pop_depth  = depth_q - {3'b0, pop};
    stk_id_d   = stk_id_q;
    stk_prio_d = stk_prio_q;
    // pop happens before push, so a same-cycle claim replaces the completed top
    if (push) begin
      stk_id_d[AW'(pop_depth)]   = lat_id_q;
      stk_prio_d[AW'(pop_depth)] = lat_prio_q;
    end
    depth_d    = pop_depth + {3'b0, push};
    cur_prio_d = depth_d == 4'd0 ? '0 : stk_prio_d[AW'(depth_d - 4'd1)];
    state_d    = !push && qual ? REQ : IDLE;
    lat_id_d   = state_d == REQ ? bus.cand_id_i : '0;
    lat_prio_d = state_d == REQ ? bus.cand_prio_i : '0;
    clr_pend_d = push;
    clr_id_d   = push ? lat_id_q : '0;
    err_d      = (bus.complete_i && !pop) || (bus.claim_i && state_q == IDLE) || (err_q && !bus.err_clr_i);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lat_id_q   <= '0;
      lat_prio_q <= '0;
      stk_id_q   <= '{default: '0};
      stk_prio_q <= '{default: '0};
      depth_q    <= '0;
      cur_prio_q <= '0;
      clr_pend_q <= 1'b0;
      clr_id_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_id_q   <= lat_id_d;
      lat_prio_q <= lat_prio_d;
      stk_id_q   <= stk_id_d;
      stk_prio_q <= stk_prio_d;
      depth_q    <= depth_d;
      cur_prio_q <= cur_prio_d;
      clr_pend_q <= clr_pend_d;
      clr_id_q   <= clr_id_d;
      err_q      <= err_d;
    end
  end
  assign bus.irq_o      = state_q == REQ;
  assign bus.irq_id_o   = {3'b0, lat_id_q};
  assign bus.clr_pend_o = clr_pend_q;
  assign bus.clr_id_o   = clr_id_q;
  assign bus.cur_prio_o = cur_prio_q;
  assign bus.depth_o    = depth_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_rvic_claim_ctrl.sv
// tb_rvic_claim_ctrl: directed self-checking bench for the claim/complete sequencer (NEST_DEPTH=2)
module tb_rvic_claim_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  rvic_claim_ctrl_if #(.PRIO_W(8)) bus ();
  rvic_claim_ctrl #(.NEST_DEPTH(2), .PRIO_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cand(input logic v, input logic [4:0] id, input logic [7:0] prio);
    bus.cand_valid_i = v;
    bus.cand_id_i    = id;
    bus.cand_prio_i  = prio;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_irq"}, 32'(bus.irq_o), 0);
    chk({tag, "_irq_id"}, 32'(bus.irq_id_o), 0);
    chk({tag, "_clr_pend"}, 32'(bus.clr_pend_o), 0);
    chk({tag, "_clr_id"}, 32'(bus.clr_id_o), 0);
    chk({tag, "_cur_prio"}, 32'(bus.cur_prio_o), 0);
    chk({tag, "_depth"}, 32'(bus.depth_o), 0);
    chk({tag, "_err"}, 32'(bus.err_o), 0);
  endtask
  task automatic claim_pulse();
    bus.claim_i = 1'b1;
    tick();
    bus.claim_i = 1'b0;
  endtask
  task automatic complete_pulse(input logic [4:0] id);
    bus.complete_i    = 1'b1;
    bus.complete_id_i = id;
    tick();
    bus.complete_i    = 1'b0;
  endtask
  initial begin
    cand(1'b0, 5'd0, 8'd0);
    bus.threshold_i = 8'd0;
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    bus.complete_id_i = 5'd0;
    bus.err_clr_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");
    // basic request / claim / complete
    cand(1'b1, 5'd5, 8'd3);
    tick();
    chk("basic_irq", 32'(bus.irq_o), 1);
    chk("basic_irq_id", 32'(bus.irq_id_o), 5);
    claim_pulse();
    chk("basic_clr_pend", 32'(bus.clr_pend_o), 1);
    chk("basic_clr_id", 32'(bus.clr_id_o), 5);
    chk("basic_irq_drop", 32'(bus.irq_o), 0);
    chk("basic_depth1", 32'(bus.depth_o), 1);
    chk("basic_cur_prio3", 32'(bus.cur_prio_o), 3);
    tick();
    chk("basic_clr_pend_1cyc", 32'(bus.clr_pend_o), 0);
    chk("basic_no_rerequest", 32'(bus.irq_o), 0);
    cand(1'b0, 5'd0, 8'd0);
    complete_pulse(5'd5);
    chk("basic_depth0", 32'(bus.depth_o), 0);
    chk("basic_cur_prio0", 32'(bus.cur_prio_o), 0);
    chk("basic_err", 32'(bus.err_o), 0);
    // threshold gate
    bus.threshold_i = 8'd4;
    cand(1'b1, 5'd2, 8'd4);
    tick();
    chk("thr_equal_blocked", 32'(bus.irq_o), 0);
    cand(1'b1, 5'd2, 8'd5);
    tick();
    chk("thr_above_irq", 32'(bus.irq_o), 1);
    chk("thr_above_id", 32'(bus.irq_id_o), 2);
    cand(1'b0, 5'd0, 8'd0);
    tick();
    chk("thr_withdraw", 32'(bus.irq_o), 0);
    bus.threshold_i = 8'd0;
    // preemption and stack full
    cand(1'b1, 5'd1, 8'd2);
    tick();
    chk("pre_irq_id1", 32'(bus.irq_id_o), 1);
    claim_pulse();
    chk("pre_depth1", 32'(bus.depth_o), 1);
    chk("pre_cur2", 32'(bus.cur_prio_o), 2);
    cand(1'b1, 5'd7, 8'd6);
    tick();
    chk("pre_irq7", 32'(bus.irq_o), 1);
    chk("pre_irq_id7", 32'(bus.irq_id_o), 7);
    claim_pulse();
    chk("pre_depth2", 32'(bus.depth_o), 2);
    chk("pre_cur6", 32'(bus.cur_prio_o), 6);
    cand(1'b1, 5'd9, 8'd9);
    tick();
    chk("full_blocked_a", 32'(bus.irq_o), 0);
    tick();
    chk("full_blocked_b", 32'(bus.irq_o), 0);
    complete_pulse(5'd7);
    chk("full_pop_depth1", 32'(bus.depth_o), 1);
    chk("full_pop_cur2", 32'(bus.cur_prio_o), 2);
    chk("full_pop_irq_still0", 32'(bus.irq_o), 0);
    tick();
    chk("unblocked_irq", 32'(bus.irq_o), 1);
    chk("unblocked_id9", 32'(bus.irq_id_o), 9);
    cand(1'b0, 5'd0, 8'd0);
    tick();
    chk("unblocked_withdraw", 32'(bus.irq_o), 0);
    complete_pulse(5'd1);
    chk("pre_depth0", 32'(bus.depth_o), 0);
    chk("pre_cur0", 32'(bus.cur_prio_o), 0);
    chk("pre_err", 32'(bus.err_o), 0);
    // retarget, withdraw, claim during candidate change
    cand(1'b1, 5'd3, 8'd2);
    tick();
    chk("rt_id3", 32'(bus.irq_id_o), 3);
    cand(1'b1, 5'd4, 8'd5);
    tick();
    chk("rt_irq", 32'(bus.irq_o), 1);
    chk("rt_id4", 32'(bus.irq_id_o), 4);
    cand(1'b0, 5'd0, 8'd0);
    tick();
    chk("rt_withdraw", 32'(bus.irq_o), 0);
    cand(1'b1, 5'd3, 8'd2);
    tick();
    chk("rt_id3_again", 32'(bus.irq_id_o), 3);
    cand(1'b1, 5'd4, 8'd5);
    claim_pulse();
    chk("rt_claim_old_id", 32'(bus.clr_id_o), 3);
    chk("rt_claim_old_prio", 32'(bus.cur_prio_o), 2);
    chk("rt_claim_depth", 32'(bus.depth_o), 1);
    cand(1'b0, 5'd0, 8'd0);
    complete_pulse(5'd3);
    chk("rt_pop_old_id", 32'(bus.depth_o), 0);
    chk("rt_pop_err", 32'(bus.err_o), 0);
    // errors
    cand(1'b1, 5'd6, 8'd4);
    tick();
    claim_pulse();
    cand(1'b0, 5'd0, 8'd0);
    chk("err_setup_depth", 32'(bus.depth_o), 1);
    complete_pulse(5'd2);
    chk("err_bad_complete", 32'(bus.err_o), 1);
    chk("err_depth_kept", 32'(bus.depth_o), 1);
    chk("err_cur_kept", 32'(bus.cur_prio_o), 4);
    bus.err_clr_i = 1'b1;
    tick();
    bus.err_clr_i = 1'b0;
    chk("err_clear", 32'(bus.err_o), 0);
    claim_pulse();
    chk("err_idle_claim", 32'(bus.err_o), 1);
    chk("err_idle_claim_no_pend", 32'(bus.clr_pend_o), 0);
    chk("err_idle_claim_depth", 32'(bus.depth_o), 1);
    bus.err_clr_i = 1'b1;
    claim_pulse();
    chk("err_set_wins", 32'(bus.err_o), 1);
    tick();
    bus.err_clr_i = 1'b0;
    chk("err_clear2", 32'(bus.err_o), 0);
    complete_pulse(5'd6);
    chk("err_pop6", 32'(bus.depth_o), 0);
    // simultaneous claim and complete
    cand(1'b1, 5'd1, 8'd2);
    tick();
    claim_pulse();
    chk("sim_setup_depth", 32'(bus.depth_o), 1);
    cand(1'b1, 5'd8, 8'd7);
    tick();
    chk("sim_irq_id8", 32'(bus.irq_id_o), 8);
    bus.claim_i = 1'b1;
    bus.complete_i = 1'b1;
    bus.complete_id_i = 5'd1;
    tick();
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b0;
    chk("sim_depth", 32'(bus.depth_o), 1);
    chk("sim_cur7", 32'(bus.cur_prio_o), 7);
    chk("sim_clr_id8", 32'(bus.clr_id_o), 8);
    chk("sim_err", 32'(bus.err_o), 0);
    cand(1'b0, 5'd0, 8'd0);
    complete_pulse(5'd8);
    chk("sim_top_is8", 32'(bus.depth_o), 0);
    chk("sim_top_is8_err", 32'(bus.err_o), 0);
    // reset in the middle of a request, with one interrupt nested
    cand(1'b1, 5'd5, 8'd3);
    tick();
    claim_pulse();
    cand(1'b1, 5'd10, 8'd9);
    tick();
    chk("rst_pre_irq", 32'(bus.irq_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cand(1'b0, 5'd0, 8'd0);
    chk_zero("rst_mid");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
